aes_ark_slice_engine: RTL and testbench

- Parametrised, sequential successor to the combinational AES add-round-key stage.
- Holds an internal bank of pre-loaded 128-bit round keys, selected per transaction by round index.
- XORs the selected key into the 128-bit state one SLICE_W-bit slice per cycle, so one narrow XOR datapath serves area-constrained encrypt and decrypt pipelines.
- Valid/ready handshakes on input and output; flags any transaction that uses an unloaded or out-of-range key.

---
 rtl/aes_ark_slice_engine.sv | 144 ++++++++++++++
 tb/tb_aes_ark_slice_engine.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ark_slice_engine.sv
// Sliced AES add-round-key engine: XORs a banked 128-bit round key into the state SLICE_W bits per cycle.
// Optional build macro AES_ARK_ZEROIZE_EN adds the key_zeroize port (bank/working clear and abort).
module aes_ark_slice_engine #(
  parameter int SLICE_W  = 32,
  parameter int NUM_KEYS = 15,
  parameter int KIDX_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef AES_ARK_ZEROIZE_EN
  input  logic              key_zeroize,
`endif
  input  logic              key_wr_en,
  input  logic [KIDX_W-1:0] key_wr_idx,
  input  logic [127:0]      key_wr_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_state,
  input  logic [KIDX_W-1:0] in_round,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_state,
  output logic [KIDX_W-1:0] out_round,
  output logic              out_err
);

  localparam int NSLICE = 128 / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [127:0]        r_work;
  logic [127:0]        r_key;
  logic [KIDX_W-1:0]   r_round;
  logic                r_err;
  logic [127:0]        r_bank [NUM_KEYS];
  logic [NUM_KEYS-1:0] r_loaded;

  logic                w_zeroize;
  logic                w_inReady;
  logic                w_accept;
  logic [127:0]        w_bankKey;
  logic                w_hit;

`ifdef AES_ARK_ZEROIZE_EN
  assign w_zeroize = key_zeroize;
`else
  assign w_zeroize = 1'b0;
`endif

  // Out-of-range indices match no entry, so they naturally read as unloaded.
  always_comb begin
    w_bankKey = '0;
    w_hit     = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (in_round == KIDX_W'(k)) begin
        w_bankKey = r_bank[k];
        w_hit     = r_loaded[k];
      end
    end
  end

  always_comb begin
    w_inReady = 1'b0;
    w_next    = r_state;
    case (r_state)
      IDLE: w_inReady = 1'b1;
      DONE: w_inReady = out_ready;
      default: w_inReady = 1'b0;
    endcase
    if (w_zeroize) w_inReady = 1'b0;
    w_accept = in_valid && w_inReady;

    if (w_zeroize) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_accept) w_next = BUSY;
        BUSY: if (r_cnt == LAST_SLICE) w_next = DONE;
        DONE: if (out_ready) w_next = w_accept ? BUSY : IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
      r_key   <= '0;
      r_round <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_zeroize) begin
        r_cnt  <= '0;
        r_work <= '0;
        r_key  <= '0;
        r_err  <= 1'b0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_work  <= in_state;
        r_round <= in_round;
        r_key   <= w_hit ? w_bankKey : '0;
        r_err   <= ~w_hit;
      end else if (r_state == BUSY) begin
        r_work[int'(r_cnt)*SLICE_W +: SLICE_W] <=
          r_work[int'(r_cnt)*SLICE_W +: SLICE_W] ^ r_key[int'(r_cnt)*SLICE_W +: SLICE_W];
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // The accept path reads the bank before this edge, so a colliding write is seen only by later accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loaded <= '0;
      for (int k = 0; k < NUM_KEYS; k++) r_bank[k] <= '0;
    end else if (w_zeroize) begin
      r_loaded <= '0;
      for (int k = 0; k < NUM_KEYS; k++) r_bank[k] <= '0;
    end else if (key_wr_en) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (key_wr_idx == KIDX_W'(k)) begin
          r_bank[k]   <= key_wr_data;
          r_loaded[k] <= 1'b1;
        end
      end
    end
  end

  // Partially keyed working data never reaches out_state outside DONE.
  assign in_ready  = w_inReady;
  assign out_valid = (r_state == DONE);
  assign out_state = (r_state == DONE) ? r_work : '0;
  assign out_round = r_round;
  assign out_err   = (r_state == DONE) && r_err;

endmodule

// File: tb/tb_aes_ark_slice_engine.sv
// Directed bench for aes_ark_slice_engine: reference key bank model plus an expected-result queue.
module tb_aes_ark_slice_engine;

  localparam int SLICE_W  = 32;
  localparam int NUM_KEYS = 15;
  localparam int KIDX_W   = 4;
  localparam int NSLICE   = 128 / SLICE_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              key_wr_en = 1'b0;
  logic [KIDX_W-1:0] key_wr_idx = '0;
  logic [127:0]      key_wr_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [127:0]      in_state = '0;
  logic [KIDX_W-1:0] in_round = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [127:0]      out_state;
  logic [KIDX_W-1:0] out_round;
  logic              out_err;
`ifdef AES_ARK_ZEROIZE_EN
  logic              key_zeroize = 1'b0;
`endif

  aes_ark_slice_engine #(.SLICE_W(SLICE_W), .NUM_KEYS(NUM_KEYS), .KIDX_W(KIDX_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef AES_ARK_ZEROIZE_EN
    .key_zeroize(key_zeroize),
`endif
    .key_wr_en(key_wr_en),
    .key_wr_idx(key_wr_idx),
    .key_wr_data(key_wr_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_state(in_state),
    .in_round(in_round),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_state(out_state),
    .out_round(out_round),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0]      st;
    logic [KIDX_W-1:0] rnd;
    logic              err;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] refBank [16];
  logic         refLoaded [16];
  int           total = 0;
  int           bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 16; i++) begin
      refBank[i]   = '0;
      refLoaded[i] = 1'b0;
    end
    sb.delete();
  endtask

  task automatic writeKey(input logic [KIDX_W-1:0] idx, input logic [127:0] data);
    key_wr_en   = 1'b1;
    key_wr_idx  = idx;
    key_wr_data = data;
    @(posedge clk);
    if (int'(idx) < NUM_KEYS) begin
      refBank[idx]   = data;
      refLoaded[idx] = 1'b1;
    end
    @(negedge clk);
    key_wr_en = 1'b0;
  endtask

  // Expected value is taken from the model before any same-cycle key write updates it.
  task automatic applyStimulus(input logic [127:0] st, input logic [KIDX_W-1:0] rnd,
                               input logic wrEn, input logic [KIDX_W-1:0] wrIdx,
                               input logic [127:0] wrData);
    exp_t e;
    int   waitCnt;
    in_valid    = 1'b1;
    in_state    = st;
    in_round    = rnd;
    key_wr_en   = wrEn;
    key_wr_idx  = wrIdx;
    key_wr_data = wrData;
    #1;
    waitCnt = 0;
    while (in_ready !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      #1;
      waitCnt++;
    end
    chk("accept_ready", 128'(in_ready), 128'(1));
    e.err = (int'(rnd) >= NUM_KEYS) || !refLoaded[rnd];
    e.st  = e.err ? st : (st ^ refBank[rnd]);
    e.rnd = rnd;
    @(posedge clk);
    sb.push_back(e);
    if (wrEn && int'(wrIdx) < NUM_KEYS) begin
      refBank[wrIdx]   = wrData;
      refLoaded[wrIdx] = 1'b1;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    key_wr_en = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    int   lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, 128'(out_valid), 128'(1));
    chk({tag, "_latency"}, 128'(lat), 128'(NSLICE));
    e = '{default: '0};
    if (sb.size() > 0) e = sb.pop_front();
    chk({tag, "_state"}, out_state, e.st);
    chk({tag, "_round"}, 128'(out_round), 128'(e.rnd));
    chk({tag, "_err"}, 128'(out_err), 128'(e.err));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] bpExp;
    logic [127:0] s;
    clearModel();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_state", out_state, 128'(0));
    chk("rst_out_round", 128'(out_round), 128'(0));
    chk("rst_out_err", 128'(out_err), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    writeKey(4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    applyStimulus(128'h00112233445566778899aabbccddeeff, 4'd0, 1'b0, 4'd0, '0);
    checkOutput("fips");
    chk("fips_literal", out_state, 128'h00102030405060708090a0b0c0d0e0f0);
    @(negedge clk);

    writeKey(4'd1, 128'hdeadbeef_01234567_89abcdef_cafef00d);
    writeKey(4'd3, 128'h11111111_22222222_33333333_44444444);
    writeKey(4'd15, 128'hffffffff_ffffffff_ffffffff_ffffffff);

    out_ready = 1'b0;
    applyStimulus(128'h0f0e0d0c_0b0a0908_07060504_03020100, 4'd1, 1'b0, 4'd0, '0);
    checkOutput("bp1");
    bpExp = 128'h0f0e0d0c_0b0a0908_07060504_03020100 ^ 128'hdeadbeef_01234567_89abcdef_cafef00d;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 128'(out_valid), 128'(1));
      chk("bp_hold_state", out_state, bpExp);
      chk("bp_hold_round", 128'(out_round), 128'(1));
      chk("bp_hold_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    applyStimulus(128'ha5a5a5a5_5a5a5a5a_0000ffff_ffff0000, 4'd0, 1'b0, 4'd0, '0);
    checkOutput("bp2");

    applyStimulus(128'h13579bdf_2468ace0_fedcba98_76543210, 4'd5, 1'b0, 4'd0, '0);
    checkOutput("unl5");
    chk("unl5_passthru", out_state, 128'h13579bdf_2468ace0_fedcba98_76543210);
    applyStimulus(128'h0badf00d_0badf00d_0badf00d_0badf00d, 4'd15, 1'b0, 4'd0, '0);
    checkOutput("unl15");

    applyStimulus(128'h01010101_02020202_03030303_04040404, 4'd3, 1'b1, 4'd3,
                  128'h55555555_66666666_77777777_88888888);
    checkOutput("coll_old");
    chk("coll_old_literal", out_state, 128'h10101010_20202020_30303030_40404040);
    applyStimulus(128'h01010101_02020202_03030303_04040404, 4'd3, 1'b0, 4'd0, '0);
    checkOutput("coll_new");

    for (int i = 0; i < 6; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(s, KIDX_W'(i % 4), 1'b0, 4'd0, '0);
      checkOutput("mix");
    end

    applyStimulus(128'hcafebabe_cafebabe_cafebabe_cafebabe, 4'd0, 1'b0, 4'd0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    clearModel();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", 128'(out_valid), 128'(0));
    end
    applyStimulus(128'h00112233445566778899aabbccddeeff, 4'd0, 1'b0, 4'd0, '0);
    checkOutput("post_rst");
    chk("post_rst_err", 128'(out_err), 128'(1));

`ifdef AES_ARK_ZEROIZE_EN
    @(negedge clk);
    writeKey(4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    applyStimulus(128'h00112233445566778899aabbccddeeff, 4'd0, 1'b0, 4'd0, '0);
    key_zeroize = 1'b1;
    @(negedge clk);
    key_zeroize = 1'b0;
    clearModel();
    for (int i = 0; i < 8; i++) begin
      chk("zero_no_valid", 128'(out_valid), 128'(0));
      @(negedge clk);
    end
    applyStimulus(128'h00112233445566778899aabbccddeeff, 4'd0, 1'b0, 4'd0, '0);
    checkOutput("post_zero");
    chk("post_zero_passthru", out_state, 128'h00112233445566778899aabbccddeeff);
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
